and_reduce_seq: RTL and testbench

AND_REDUCE_SEQ -- requirements
Module: and_reduce_seq

---
 rtl/and_reduce_seq.sv | 112 +++++++++++
 tb/tb_and_reduce_seq.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/and_reduce_seq.sv
// Sequential AND-reduction of a WIDTH-bit operand through one shared CHUNK-wide and_cascade.
// Optional build macro EARLY_EXIT_EN: leave RUN as soon as a chunk reduces to zero.
`timescale 1ns/1ps

module and_cascade #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  output logic         y
);
  logic [N:0] c;

  assign c[0] = 1'b1;
  for (genvar i = 0; i < N; i++) begin : g_stage
    assign c[i+1] = c[i] & a[i];
  end
  assign y = c[N];
endmodule

module and_reduce_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] vec_in,
  output logic             busy,
  output logic             done,
  output logic             y
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] operand;
  logic             acc;
  logic [IW-1:0]    idx;
  logic [CHUNK-1:0] chunk;
  logic             cascade_y;
  logic             last;
  logic             early;

  always_comb begin
    chunk = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (32'(idx) == i) chunk = operand[i*CHUNK +: CHUNK];
    end
  end

  and_cascade #(.N(CHUNK)) u_cascade (
    .a (chunk),
    .y (cascade_y)
  );

  assign last = (idx == IW'(NCHUNK - 1));

`ifdef EARLY_EXIT_EN
  assign early = ~cascade_y;
`else
  assign early = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last || early) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // idx stops at the last chunk so it never wraps; early exit needs no zeroing
  // of y since acc & cascade_y is already 0 in that case.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      operand <= '0;
      acc     <= 1'b1;
      idx     <= '0;
      y       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            operand <= vec_in;
            acc     <= 1'b1;
            idx     <= '0;
          end
        end
        RUN: begin
          acc <= acc & cascade_y;
          if (!last) idx <= idx + IW'(1);
          if (last || early) y <= acc & cascade_y;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_and_reduce_seq.sv
// Directed self-checking bench for and_reduce_seq (WIDTH=32, CHUNK=8), either EARLY_EXIT_EN build.
`timescale 1ns/1ps

module tb_and_reduce_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] vec_in = '0;
  logic        busy, done, y;

  int checks = 0;
  int errors = 0;

`ifdef EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  always #5 clk = ~clk;

  and_reduce_seq #(.WIDTH(32), .CHUNK(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .vec_in (vec_in),
    .busy   (busy),
    .done   (done),
    .y      (y)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launches one operation from IDLE; lat = edges after the start edge until done is seen.
  task automatic launch(input logic [31:0] v, output int lat, output int busy_n);
    vec_in = v;
    start  = 1'b1;
    step();
    start  = 1'b0;
    lat    = 0;
    busy_n = 0;
    while (!done && lat < 20) begin
      if (busy) busy_n++;
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (y !== 1'b0)    begin errors++; $display("FAIL reset_y got=%b exp=0", y); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_all_ones();
    int lat, bn;
    launch(32'hFFFF_FFFF, lat, bn);
    checks++; if (lat !== 4) begin errors++; $display("FAIL ones_latency got=%0d exp=4", lat); end
    checks++; if (bn !== 4)  begin errors++; $display("FAIL ones_busy_cycles got=%0d exp=4", bn); end
    checks++; if (y !== 1'b1) begin errors++; $display("FAIL ones_y got=%b exp=1", y); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL ones_done_single got=%b exp=0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ones_idle_busy got=%b exp=0", busy); end
    checks++; if (y !== 1'b1) begin errors++; $display("FAIL ones_y_held got=%b exp=1", y); end
  endtask

  task automatic test_zero_patterns();
    int lat, bn;
    launch(32'hFFFF_FFFE, lat, bn);
    checks++; if (lat !== (EE ? 1 : 4)) begin errors++; $display("FAIL fe_latency got=%0d exp=%0d", lat, EE ? 1 : 4); end
    checks++; if (y !== 1'b0) begin errors++; $display("FAIL fe_y got=%b exp=0", y); end
    step();
    launch(32'hFFFF_FFFF, lat, bn);
    checks++; if (y !== 1'b1) begin errors++; $display("FAIL ones_again_y got=%b exp=1", y); end
    step();
    launch(32'h7FFF_FFFF, lat, bn);
    checks++; if (lat !== 4) begin errors++; $display("FAIL msb0_latency got=%0d exp=4", lat); end
    checks++; if (y !== 1'b0) begin errors++; $display("FAIL msb0_y got=%b exp=0", y); end
    step();
    launch(32'hFFFF_FFFF, lat, bn);
    step();
    launch(32'h0000_0000, lat, bn);
    checks++; if (lat !== (EE ? 1 : 4)) begin errors++; $display("FAIL zero_latency got=%0d exp=%0d", lat, EE ? 1 : 4); end
    checks++; if (y !== 1'b0) begin errors++; $display("FAIL zero_y got=%b exp=0", y); end
    step();
    launch(32'hFF7F_FFFF, lat, bn);
    checks++; if (lat !== (EE ? 3 : 4)) begin errors++; $display("FAIL chunk2_latency got=%0d exp=%0d", lat, EE ? 3 : 4); end
    checks++; if (y !== 1'b0) begin errors++; $display("FAIL chunk2_y got=%b exp=0", y); end
    step();
  endtask

  task automatic test_ignore_start();
    int n, extra_busy, extra_done;
    vec_in = 32'hFFFF_FFFF;
    start  = 1'b1;
    step();
    start  = 1'b0;
    step();
    vec_in = 32'h0000_0000;
    start  = 1'b1;
    step();
    start  = 1'b0;
    n = 2;
    while (!done && n < 20) begin
      step();
      n++;
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL ign_latency got=%0d exp=4", n); end
    checks++; if (y !== 1'b1) begin errors++; $display("FAIL ign_y got=%b exp=1", y); end
    extra_busy = 0;
    extra_done = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (busy) extra_busy++;
      if (done) extra_done++;
    end
    checks++; if (extra_busy !== 0) begin errors++; $display("FAIL ign_second_op busy_cycles=%0d exp=0", extra_busy); end
    checks++; if (extra_done !== 0) begin errors++; $display("FAIL ign_second_done pulses=%0d exp=0", extra_done); end
  endtask

  task automatic test_reset_abort();
    int pulses;
    vec_in = 32'hFFFF_FFFF;
    start  = 1'b1;
    step();
    start  = 1'b0;
    step();
    rst_n  = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", done); end
    checks++; if (y !== 1'b0)    begin errors++; $display("FAIL abort_y got=%b exp=0", y); end
    rst_n  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done || busy) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_activity got=%0d exp=0", pulses); end
  endtask

  task automatic test_start_at_reset_release();
    int n;
    rst_n  = 1'b0;
    start  = 1'b1;
    vec_in = 32'hFFFF_FFFF;
    step();
    rst_n = 1'b1;
    step();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rel_accept got=%b exp=1", busy); end
    n = 0;
    while (!done && n < 20) begin
      step();
      n++;
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL rel_latency got=%0d exp=4", n); end
    checks++; if (y !== 1'b1) begin errors++; $display("FAIL rel_y got=%b exp=1", y); end
    step();
  endtask

  task automatic test_back_to_back();
    int t[3];
    int cnt, cyc;
    vec_in = 32'hFFFF_FFFF;
    start  = 1'b1;
    cnt = 0;
    cyc = 0;
    while (cnt < 3 && cyc < 40) begin
      step();
      cyc++;
      if (done) begin
        t[cnt] = cyc;
        cnt++;
      end
    end
    start = 1'b0;
    checks++; if (cnt !== 3) begin errors++; $display("FAIL b2b_pulses got=%0d exp=3", cnt); end
    checks++; if (cnt == 3 && (t[1] - t[0]) !== 6) begin errors++; $display("FAIL b2b_period1 got=%0d exp=6", t[1] - t[0]); end
    checks++; if (cnt == 3 && (t[2] - t[1]) !== 6) begin errors++; $display("FAIL b2b_period2 got=%0d exp=6", t[2] - t[1]); end
    checks++; if (y !== 1'b1) begin errors++; $display("FAIL b2b_y got=%b exp=1", y); end
    for (int i = 0; i < 10; i++) step();
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_zero_patterns();
    test_ignore_start();
    test_reset_abort();
    test_start_at_reset_release();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
